// File: rtl/pipelined_barrel_shifter.sv
// Pipelined multi-mode barrel shifter for FPU mantissa alignment/normalisation.
// Modes: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right.
// Define BARREL_ROTATE_EN to build the rotate path; otherwise mode 11 acts as 01.
// Log2 mux stage k shifts by 2**k; a register slice follows every StagesPerReg
// stages and the last stage, giving ceil(NumStages/StagesPerReg) cycles latency.
module pipelined_barrel_shifter #(
  parameter int unsigned DataWidth    = 32,
  parameter int unsigned MaxShift     = 31,
  parameter int unsigned StagesPerReg = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              valid_i,
  output logic                              ready_o,
  input  logic [DataWidth-1:0]              data_i,
  input  logic [$clog2(MaxShift+1)-1:0]     shift_amount_i,
  input  logic [1:0]                        mode_i,
  output logic                              valid_o,
  input  logic                              ready_i,
  output logic [DataWidth-1:0]              data_o,
  output logic                              sticky_o
);

  localparam int unsigned AmtW      = $clog2(MaxShift + 1);
  localparam int unsigned NumStages = AmtW;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROR = 2'b11;

  logic                 en;
  logic                 amt_sat;
  logic [DataWidth-1:0] pre_data;
  logic                 pre_sticky;
  logic [1:0]           pre_mode;
  logic [AmtW-1:0]      pre_amt;

  // Global pipeline enable: advance unless a result is stuck at the output
  assign en      = ready_i | ~valid_o;
  assign ready_o = en;

  // Amounts above MaxShift only exist when MaxShift+1 is not a power of two
  if (((32'd1 << AmtW) - 32'd1) > MaxShift) begin : g_sat
    assign amt_sat = shift_amount_i > AmtW'(MaxShift);
  end else begin : g_nosat
    assign amt_sat = 1'b0;
  end

  // Mode folding and saturation handled up front so the mux stages stay uniform
  always_comb begin
    pre_mode   = mode_i;
`ifndef BARREL_ROTATE_EN
    if (mode_i == MODE_ROR) pre_mode = MODE_SRL;
`endif
    pre_data   = data_i;
    pre_sticky = 1'b0;
    pre_amt    = shift_amount_i;
    if (amt_sat && (pre_mode != MODE_ROR)) begin
      pre_amt = '0;
      if (pre_mode == MODE_SRA) begin
        // Saturates to a shift of DataWidth-1: only sign copies remain
        pre_data   = {DataWidth{data_i[DataWidth-1]}};
        pre_sticky = |data_i[DataWidth-2:0];
      end else begin
        pre_data   = '0;
        pre_sticky = |data_i;
      end
    end
  end

  for (genvar k = 0; k < NumStages; k++) begin : g_stage
    localparam int unsigned Sh     = 32'd1 << k;
    localparam bit          HasReg = (((k + 1) % StagesPerReg) == 0) || (k == NumStages - 1);

    logic [DataWidth-1:0] in_data, data_d, out_data;
    logic                 in_valid, in_sticky, sticky_d, out_valid, out_sticky;
    logic [1:0]           in_mode, out_mode;
    logic [AmtW-1:0]      in_amt, out_amt;

    if (k == 0) begin : g_src_in
      assign in_data   = pre_data;
      assign in_valid  = valid_i;
      assign in_sticky = pre_sticky;
      assign in_mode   = pre_mode;
      assign in_amt    = pre_amt;
    end else begin : g_src_prev
      assign in_data   = g_stage[k-1].out_data;
      assign in_valid  = g_stage[k-1].out_valid;
      assign in_sticky = g_stage[k-1].out_sticky;
      assign in_mode   = g_stage[k-1].out_mode;
      assign in_amt    = g_stage[k-1].out_amt;
    end

    // Shift by 2**k when amount bit k is set, folding discarded bits into sticky
    always_comb begin
      data_d   = in_data;
      sticky_d = in_sticky;
      if (in_amt[k]) begin
        case (in_mode)
          MODE_SLL: begin
            data_d   = {in_data[DataWidth-1-Sh:0], {Sh{1'b0}}};
            sticky_d = in_sticky | (|in_data[DataWidth-1 -: Sh]);
          end
          MODE_SRA: begin
            data_d   = {{Sh{in_data[DataWidth-1]}}, in_data[DataWidth-1:Sh]};
            sticky_d = in_sticky | (|in_data[Sh-1:0]);
          end
`ifdef BARREL_ROTATE_EN
          MODE_ROR: begin
            data_d = {in_data[Sh-1:0], in_data[DataWidth-1:Sh]};
          end
`endif
          default: begin
            data_d   = {{Sh{1'b0}}, in_data[DataWidth-1:Sh]};
            sticky_d = in_sticky | (|in_data[Sh-1:0]);
          end
        endcase
      end
    end

    if (HasReg) begin : g_reg
      logic [DataWidth-1:0] data_q;
      logic                 valid_q, sticky_q;
      logic [1:0]           mode_q;
      logic [AmtW-1:0]      amt_q;

      // Register slice; whole pipeline holds together when en is low
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          data_q   <= '0;
          valid_q  <= 1'b0;
          sticky_q <= 1'b0;
          mode_q   <= '0;
          amt_q    <= '0;
        end else if (en) begin
          data_q   <= data_d;
          valid_q  <= in_valid;
          sticky_q <= sticky_d;
          mode_q   <= in_mode;
          amt_q    <= in_amt;
        end
      end

      assign out_data   = data_q;
      assign out_valid  = valid_q;
      assign out_sticky = sticky_q;
      assign out_mode   = mode_q;
      assign out_amt    = amt_q;
    end else begin : g_comb
      assign out_data   = data_d;
      assign out_valid  = in_valid;
      assign out_sticky = sticky_d;
      assign out_mode   = in_mode;
      assign out_amt    = in_amt;
    end
  end

  assign data_o   = g_stage[NumStages-1].out_data;
  assign valid_o  = g_stage[NumStages-1].out_valid;
  assign sticky_o = g_stage[NumStages-1].out_sticky;

  // Mode and amount are not needed past the final stage
  logic unused_tail;
  assign unused_tail = ^{g_stage[NumStages-1].out_mode, g_stage[NumStages-1].out_amt};

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed bench for pipelined_barrel_shifter: an 8-bit MaxShift=7 instance (a),
// an 8-bit MaxShift=5 instance (b) sharing a's stimulus, and a default 32-bit instance (c).
module tb_pipelined_barrel_shifter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       rdy;
  logic       va;
  logic [7:0] da;
  logic [2:0] amta;
  logic [1:0] modea;
  logic       rdyo_a, vo_a, so_a;
  logic [7:0] do_a;
  logic       rdyo_b, vo_b, so_b;
  logic [7:0] do_b;

  logic        vc;
  logic [31:0] dc;
  logic [4:0]  amtc;
  logic [1:0]  modec;
  logic        rdyo_c, vo_c, so_c;
  logic [31:0] do_c;

  int n_checks = 0;
  int n_fail   = 0;

  pipelined_barrel_shifter #(.DataWidth(8), .MaxShift(7), .StagesPerReg(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(va), .ready_o(rdyo_a), .data_i(da),
    .shift_amount_i(amta), .mode_i(modea), .valid_o(vo_a), .ready_i(rdy),
    .data_o(do_a), .sticky_o(so_a));

  pipelined_barrel_shifter #(.DataWidth(8), .MaxShift(5), .StagesPerReg(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(va), .ready_o(rdyo_b), .data_i(da),
    .shift_amount_i(amta), .mode_i(modea), .valid_o(vo_b), .ready_i(rdy),
    .data_o(do_b), .sticky_o(so_b));

  pipelined_barrel_shifter u_dut_c (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(vc), .ready_o(rdyo_c), .data_i(dc),
    .shift_amount_i(amtc), .mode_i(modec), .valid_o(vo_c), .ready_i(rdy),
    .data_o(do_c), .sticky_o(so_c));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction into a/b, wait (bounded) for the result
  task automatic xact_a(input logic [7:0] d, input logic [2:0] amt, input logic [1:0] md,
                        output logic [7:0] ra, output logic sa,
                        output logic [7:0] rb, output logic sb, output int lat);
    ra = '0; sa = 1'b0; rb = '0; sb = 1'b0; lat = -1;
    @(negedge clk);
    va = 1'b1; da = d; amta = amt; modea = md;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) va = 1'b0;
      if (vo_a) begin
        lat = i; ra = do_a; sa = so_a; rb = do_b; sb = so_b;
        break;
      end
    end
  endtask

  task automatic xact_c(input logic [31:0] d, input logic [4:0] amt, input logic [1:0] md,
                        output logic [31:0] r, output logic s, output int lat);
    r = '0; s = 1'b0; lat = -1;
    @(negedge clk);
    vc = 1'b1; dc = d; amtc = amt; modec = md;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) vc = 1'b0;
      if (vo_c) begin
        lat = i; r = do_c; s = so_c;
        break;
      end
    end
  endtask

  // Eight back-to-back inputs with amounts 0..7, results must stream one per cycle
  task automatic burst(input logic [7:0] d, input logic [1:0] md, input string tag);
    logic [7:0] got [8];
    logic       stk [8];
    int         cyc [8];
    int         n;
    logic [7:0] e;
    n = 0;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (vo_a) begin
        if (n < 8) begin got[n] = do_a; stk[n] = so_a; cyc[n] = c; end
        n++;
      end
      if (c < 8) begin
        va = 1'b1; da = d; amta = 3'(c); modea = md;
      end else begin
        va = 1'b0;
      end
    end
    check({tag, "_count"}, 32'(n), 32'd8);
    if (n >= 8) begin
      check({tag, "_first_cycle"}, 32'(cyc[0]), 32'd3);
      for (int j = 0; j < 8; j++) begin
        e = (md == 2'b00) ? (d << j) : (d >> j);
        check($sformatf("%s_data_%0d", tag, j), 32'(got[j]), 32'(e));
        check($sformatf("%s_sticky_%0d", tag, j), 32'(stk[j]), 32'd0);
        if (j > 0) check($sformatf("%s_cycle_%0d", tag, j), 32'(cyc[j] - cyc[0]), 32'(j));
      end
    end
  endtask

  // Present three transactions while ready_i is low so the pipe fills and stalls
  task automatic fill3();
    @(negedge clk);
    rdy = 1'b0; va = 1'b1; da = 8'h0F; amta = 3'd1; modea = 2'b01;
    @(negedge clk);
    da = 8'hB4; amta = 3'd2; modea = 2'b00;
    @(negedge clk);
    da = 8'h81; amta = 3'd4; modea = 2'b10;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  ra, rb;
    logic        sa, sb, sc;
    logic [31:0] rc;
    int          lat, n;
    logic [7:0]  gd [4];
    logic        gs [4];

    rst_n = 1'b0; rdy = 1'b1;
    va = 1'b0; da = '0; amta = '0; modea = '0;
    vc = 1'b0; dc = '0; amtc = '0; modec = '0;
    #1;
    check("rst_valid", 32'(vo_a), 32'd0);
    check("rst_data", 32'(do_a), 32'd0);
    check("rst_sticky", 32'(so_a), 32'd0);
    check("rst_ready", 32'(rdyo_a), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Basic modes
    xact_a(8'hB4, 3'd3, 2'b00, ra, sa, rb, sb, lat);
    check("sll_latency", 32'(lat), 32'd3);
    check("sll_data", 32'(ra), 32'hA0);
    check("sll_sticky", 32'(sa), 32'd1);
    xact_a(8'hB4, 3'd3, 2'b01, ra, sa, rb, sb, lat);
    check("srl_data", 32'(ra), 32'h16);
    check("srl_sticky", 32'(sa), 32'd1);
    xact_a(8'hB4, 3'd3, 2'b10, ra, sa, rb, sb, lat);
    check("sra_data", 32'(ra), 32'hF6);
    check("sra_sticky", 32'(sa), 32'd1);
    xact_a(8'hB4, 3'd0, 2'b10, ra, sa, rb, sb, lat);
    check("amt0_data", 32'(ra), 32'hB4);
    check("amt0_sticky", 32'(sa), 32'd0);

    // Rotate (or its logical-right fallback)
    xact_a(8'hB4, 3'd3, 2'b11, ra, sa, rb, sb, lat);
`ifdef BARREL_ROTATE_EN
    check("ror_data", 32'(ra), 32'h96);
    check("ror_sticky", 32'(sa), 32'd0);
`else
    check("ror_data", 32'(ra), 32'h16);
    check("ror_sticky", 32'(sa), 32'd1);
`endif

    // Full throughput
    burst(8'h01, 2'b00, "b2b_sll");
    burst(8'h80, 2'b01, "b2b_srl");

    // Backpressure: hold, offer a junk input, then drain
    fill3();
    da = 8'hFF; amta = 3'd7; modea = 2'b00;
    for (int i = 0; i < 5; i++) begin
      check("stall_ready", 32'(rdyo_a), 32'd0);
      check("stall_valid", 32'(vo_a), 32'd1);
      check("stall_data", 32'(do_a), 32'h07);
      @(negedge clk);
      da = 8'($urandom); amta = 3'($urandom);
    end
    rdy = 1'b1; va = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (vo_a) begin
        if (n < 4) begin gd[n] = do_a; gs[n] = so_a; end
        n++;
      end
      @(negedge clk);
    end
    check("drain_count", 32'(n), 32'd3);
    if (n >= 3) begin
      check("drain_data_0", 32'(gd[0]), 32'h07);
      check("drain_sticky_0", 32'(gs[0]), 32'd1);
      check("drain_data_1", 32'(gd[1]), 32'hD0);
      check("drain_sticky_1", 32'(gs[1]), 32'd1);
      check("drain_data_2", 32'(gd[2]), 32'hF8);
      check("drain_sticky_2", 32'(gs[2]), 32'd1);
    end

    // Saturation: b has MaxShift=5, a has MaxShift=7
    xact_a(8'hFF, 3'd7, 2'b01, ra, sa, rb, sb, lat);
    check("sat_srl_b_data", 32'(rb), 32'h00);
    check("sat_srl_b_sticky", 32'(sb), 32'd1);
    check("sat_srl_a_data", 32'(ra), 32'h01);
    check("sat_srl_a_sticky", 32'(sa), 32'd1);
    xact_a(8'h80, 3'd6, 2'b10, ra, sa, rb, sb, lat);
    check("sat_sra_b_data", 32'(rb), 32'hFF);
    check("sat_sra_b_sticky", 32'(sb), 32'd0);
    check("sat_sra_a_data", 32'(ra), 32'hFE);
    check("sat_sra_a_sticky", 32'(sa), 32'd0);
    xact_a(8'hFF, 3'd5, 2'b00, ra, sa, rb, sb, lat);
    check("inrange_b_data", 32'(rb), 32'hE0);
    check("inrange_b_sticky", 32'(sb), 32'd1);
    xact_a(8'hB4, 3'd7, 2'b11, ra, sa, rb, sb, lat);
`ifdef BARREL_ROTATE_EN
    check("ror7_a_data", 32'(ra), 32'h69);
    check("ror7_b_data", 32'(rb), 32'h69);
    check("ror7_b_sticky", 32'(sb), 32'd0);
`else
    check("ror7_a_data", 32'(ra), 32'h01);
    check("ror7_b_data", 32'(rb), 32'h00);
    check("ror7_b_sticky", 32'(sb), 32'd1);
`endif

    // Default 32-bit configuration with two mux stages per slice
    xact_c(32'h8000_0001, 5'd1, 2'b10, rc, sc, lat);
    check("c_latency", 32'(lat), 32'd3);
    check("c_sra_data", rc, 32'hC000_0000);
    check("c_sra_sticky", 32'(sc), 32'd1);
    xact_c(32'h0000_0003, 5'd31, 2'b00, rc, sc, lat);
    check("c_sll_data", rc, 32'h8000_0000);
    check("c_sll_sticky", 32'(sc), 32'd1);
    xact_c(32'hF000_0000, 5'd16, 2'b01, rc, sc, lat);
    check("c_srl_data", rc, 32'h0000_F000);
    check("c_srl_sticky", 32'(sc), 32'd0);
    xact_c(32'h1234_5678, 5'd0, 2'b01, rc, sc, lat);
    check("c_amt0_data", rc, 32'h1234_5678);

    // Asynchronous reset with work in flight
    fill3();
    va = 1'b0;
    check("prerst_valid", 32'(vo_a), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(vo_a), 32'd0);
    check("midrst_data", 32'(do_a), 32'd0);
    check("midrst_sticky", 32'(so_a), 32'd0);
    check("midrst_ready", 32'(rdyo_a), 32'd1);
    @(negedge clk);
    rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (vo_a) n++;
    end
    check("postrst_stale", 32'(n), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined, multi-mode barrel shifter for the FPU datapath, used for mantissa alignment (right shift with sticky) and normalisation (left shift).
- Generalises the single-direction combinational shifter: configurable width and max shift, left/right/arithmetic modes, sticky-bit output, register slices every N mux stages.
- Uses a valid/ready handshake so it composes with the pipelined add/sub datapath.

Parameters:
DataWidth, 32, width of data_i/data_o in bits (>=2)
MaxShift, 31, largest meaningful shift amount (1..DataWidth-1)
StagesPerReg, 2, number of log2 mux stages between pipeline registers (>=1)
(derived) NumStages = $clog2(MaxShift+1); Latency = ceil(NumStages/StagesPerReg)

Ports:
clk_i  input  1  clock; all registers on rising edge
rst_ni  input  1  asynchronous, active-low reset
valid_i  input  1  input transaction valid
ready_o  output  1  block can accept input this cycle
data_i  input  DataWidth  operand
shift_amount_i  input  $clog2(MaxShift+1)  shift distance
mode_i  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate right (optional feature)
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
data_o  output  DataWidth  shifted result
sticky_o  output  1  OR of all bits shifted out (0 for rotate)

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is asynchronous and active-low.
- Reset: every stage valid bit, data, mode, amount and sticky register cleared. valid_o=0, data_o=0, sticky_o=0, hence ready_o=1.
- Stage k applies shift 2**k when amount bit k is set; direction and fill come from mode_i.
  - Left shifts and logical right shifts fill with 0.
  - Arithmetic right shift fills with data_i[DataWidth-1].
- Sticky is accumulated per stage: sticky |= OR of bits discarded by that stage.
- Pipeline: a register slice follows every StagesPerReg mux stages and after the last stage. Latency is exactly Latency cycles from an accepted input to valid_o under no backpressure.
- Global enable: en = ready_i | ~valid_o; ready_o = en (combinational).
  - When en=1, all slices advance; slice 0 captures valid_i & ready_o.
  - When en=0, all slices hold; data_o/sticky_o are stable while valid_o=1 and ready_i=0.
- Handshakes: input accepted on valid_i & ready_o; output consumed on valid_o & ready_i. Simultaneous accept and consume in one cycle is legal and sustains full throughput (1/cycle).
- Out-of-range amount (> MaxShift, possible when MaxShift+1 is not a power of two) saturates:
  - left/logical right: data_o = 0, sticky = |data_i;
  - arithmetic right: data_o = all copies of the sign bit, sticky = OR of the non-sign-equivalent bits shifted out.
  - Rotate is taken modulo DataWidth.
- Amount 0: data_o = data_i, sticky_o = 0, for every mode.
- Mode and amount travel with the data through the slices. Changing inputs while ready_o=0 has no effect.
- Reset asserted mid-operation discards all in-flight transactions immediately (asynchronous). No partial output after rst_ni deasserts.

Optional Feature:
BARREL_ROTATE_EN
- Defined: mode_i=11 performs rotate right by shift_amount_i mod DataWidth; sticky_o=0.
- Undefined: rotate logic is not built and mode_i=11 behaves exactly as 01 (logical right, with sticky).

Test Plan:
Config DataWidth=8, MaxShift=7, StagesPerReg=1 (Latency=3), ready_i=1.
1. data 0xB4, amt 3, mode 00 -> 3 cycles later valid_o=1, data_o=0xA0, sticky_o=1; mode 01 -> 0x16, sticky 1; mode 10 -> 0xF6, sticky 1.
2. BARREL_ROTATE_EN defined: 0xB4, amt 3, mode 11 -> 0x96, sticky 0. Undefined: same stimulus -> 0x16, sticky 1.
3. Back-to-back inputs 0x01 amts 0..7, mode 00 -> outputs 0x01,0x02,...,0x80 on consecutive cycles, sticky 0; with 0x80 mode 01, sticky 0 throughout.
4. Backpressure: fill with 3 transactions, hold ready_i=0 for 5 cycles -> ready_o=0, data_o stable, no loss or duplication. Release -> results drain in order, one per cycle.
5. MaxShift=5 (amount width 3): 0xFF, amt 7, mode 01 -> data_o=0x00, sticky 1; 0x80, amt 6, mode 10 -> 0xFF, sticky 0.
6. Assert rst_ni low with 2 transactions in flight -> valid_o, data_o, sticky_o go 0 immediately, ready_o=1. After release, no stale result appears.
